mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one synchronous memory port between two requesters: port 0 is the CPU
//  FSM data path and port 1 is the I/O or display engine.
//  It runs a req/gnt/done handshake with round-robin arbitration.
//  It sequences each access through a small FSM that accounts for the memory read
//  latency, drives the memory port, and returns the read data to the winner.
// PARAMETERS
//  ADDR_W    16  address width
//  DATA_W    16  data width
//  READ_LAT   1  cycles from address presented (ACCESS) to mem_q valid; >=1
// PORTS
//  clk       in   1       system clock, rising edge
//  reset     in   1       synchronous, active-low reset
//  req0      in   1       port 0 request; held with we0/addr0/wdata0 until gnt0
//  we0       in   1       port 0: 1=write, 0=read
//  addr0     in   ADDR_W  port 0 address
//  wdata0    in   DATA_W  port 0 write data
//  req1,we1,addr1,wdata1  same as port 0, for port 1
//  mem_q     in   DATA_W  memory read data
//  mem_addr  out  ADDR_W  memory address
//  mem_d     out  DATA_W  memory write data
//  mem_we    out  1       memory write enable
//  gnt0/gnt1 out  1       one-cycle pulse: request accepted, inputs may change
//  done0/done1 out 1      one-cycle pulse: access complete; rdata valid if read
//  rdata     out  DATA_W  last read data; holds until the next read completes
//  busy      out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state<=IDLE; every output goes to 0; last_served<=1 (port 0 wins first tie).
//   - Reset aborts any access in flight: no done pulse; mem_we is 0 from the next cycle.
//  States: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
//  IDLE:
//   - Arbitrates on sampled req0/req1.
//   - Exactly one request: grant it.
//   - Both requests: grant the port != last_served.
//   - On a grant: latch we/addr/wdata, set gnt_x=1, last_served<=x, go to ACCESS.
//  ACCESS (1 cycle):
//   - mem_addr/mem_d = latched values; mem_we = latched we. gnt_x is high this cycle only.
//   - Write: go to DONE. Read: load cnt<=READ_LAT, go to WAIT.
//  WAIT (READ_LAT cycles):
//   - mem_we=0; cnt decrements each cycle.
//   - At the edge where cnt==1: rdata<=mem_q, go to DONE.
//  DONE (1 cycle):
//   - done_x=1 for the granted port; next state is IDLE.
//  Latency, measured from the grant edge (cycle 0 = ACCESS):
//   - read: done in cycle READ_LAT+1; port occupied READ_LAT+3 cycles including the IDLE arbitration cycle.
//   - write: mem_we in cycle 0, done in cycle 1; occupied 3 cycles.
//  Handshake and boundary rules:
//   - Requests arriving while busy are not sampled; they are served from IDLE.
//   - Dropping req before its gnt withdraws the request; no error.
//   - A write never changes rdata.
//   - mem_addr/mem_d hold their last latched values outside ACCESS. Only mem_we qualifies the port.
//   - gnt0&gnt1 and done0&done1 are never both high.
//   - Only one access is in flight at a time; there is no pipelining.
// TESTING
//  1. Release reset, hold 2 cycles -> all outputs 0, busy=0.
//  2. READ_LAT=1; req0 read addr 0x0010; model returns 0xBEEF -> gnt0 in cycle 0 with mem_addr=0x0010, mem_we=0; done0 in cycle 2; rdata=0xBEEF.
//  3. req1 write addr 0x0020 data 0x1234 -> mem_we=1 for exactly 1 cycle with mem_addr=0x0020, mem_d=0x1234; done1 next cycle; rdata unchanged (0xBEEF).
//  4. req0 and req1 held high for 6 accesses, reads/writes mixed -> grant order 0,1,0,1,0,1; never concurrent gnt or done.
//  5. READ_LAT=3; req1 read -> done1 exactly 4 cycles after gnt1; rdata equals mem_q sampled 3 cycles after ACCESS.
//  6. reset low during WAIT of a req0 read -> no done0; busy=0 next cycle; then req0 and req1 together -> port 0 granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one synchronous memory port between two requesters. Port 0 is the
// CPU data path and port 1 is the I/O or display engine. Requests are
// arbitrated round-robin in IDLE. The winning access is then sequenced
// through ACCESS -> (WAIT x READ_LAT for reads) -> DONE, and read data is
// returned on rdata. Only one access is in flight at a time. All outputs are
// registered.
//
// Parameters
//   ADDR_W    address width
//   DATA_W    data width
//   READ_LAT  cycles from address presented (ACCESS) to mem_q valid, >= 1
//
// Ports
//   clk                         system clock, rising edge
//   reset                       synchronous, active-low reset
//   req0/we0/addr0/wdata0       port 0 request, held until gnt0
//   req1/we1/addr1/wdata1       port 1 request, held until gnt1
//   mem_q                       memory read data
//   mem_addr/mem_d/mem_we       memory port; only mem_we qualifies it
//   gnt0/gnt1                   one-cycle pulse, request accepted
//   done0/done1                 one-cycle pulse, access complete
//   rdata                       last read data, held until the next read completes
//   busy                        high whenever the sequencer is not in IDLE

module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              last_served_q, last_served_d;
  logic              port_q, port_d;
  logic              op_we_q, op_we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_d_q, mem_d_d;
  logic              mem_we_q, mem_we_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              pick1;

  assign mem_addr = mem_addr_q;
  assign mem_d    = mem_d_q;
  assign mem_we   = mem_we_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;

  // Next-state and registered-output logic. Pulses (gnt, done) and mem_we
  // default low so that each is high for exactly the one cycle that sets it.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    port_d        = port_q;
    op_we_d       = op_we_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_d_d       = mem_d_q;
    mem_we_d      = 1'b0;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    rdata_d       = rdata_q;
    pick1         = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (req0 && req1) begin
          pick1 = ~last_served_q;
        end else begin
          pick1 = req1;
        end
        if (req0 || req1) begin
          state_d       = ACCESS;
          last_served_d = pick1;
          port_d        = pick1;
          gnt0_d        = ~pick1;
          gnt1_d        = pick1;
          op_we_d       = pick1 ? we1 : we0;
          mem_we_d      = pick1 ? we1 : we0;
          mem_addr_d    = pick1 ? addr1 : addr0;
          mem_d_d       = pick1 ? wdata1 : wdata0;
        end
      end

      ACCESS: begin
        if (op_we_q) begin
          state_d = DONE;
          done0_d = ~port_q;
          done1_d = port_q;
        end else begin
          cnt_d   = CNT_W'(READ_LAT);
          state_d = WAIT;
        end
      end

      WAIT: begin
        // cnt reaches 1 in the cycle where mem_q carries the read data.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = mem_q;
          state_d = DONE;
          done0_d = ~port_q;
          done1_d = port_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset abandons any access in flight, so no
  // done pulse is produced for it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      port_q        <= 1'b0;
      op_we_q       <= 1'b0;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_d_q       <= '0;
      mem_we_q      <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      port_q        <= port_d;
      op_we_q       <= op_we_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_d_q       <= mem_d_d;
      mem_we_q      <= mem_we_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Testbench for mem_port_arbiter. It uses two instances: dut_lat1 with
// READ_LAT=1, backed by a small memory model, and dut_lat3 with READ_LAT=3,
// whose mem_q is a per-cycle pattern so the capture cycle can be pinned down.
// Stimulus pushes expected transactions into a per-instance queue in the
// expected grant order. A monitor pops an entry on every gnt and checks it,
// then checks the matching done pulse.

module tb_mem_port_arbiter;

  typedef struct {
    int          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;

  logic        req0 [2];
  logic        we0 [2];
  logic [15:0] addr0 [2];
  logic [15:0] wdata0 [2];
  logic        req1 [2];
  logic        we1 [2];
  logic [15:0] addr1 [2];
  logic [15:0] wdata1 [2];
  logic [15:0] mem_q [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_d [2];
  logic        mem_we [2];
  logic        gnt0 [2];
  logic        gnt1 [2];
  logic        done0 [2];
  logic        done1 [2];
  logic [15:0] rdata [2];
  logic        busy [2];

  int          pass_cnt = 0;
  int          total_cnt = 0;

  exp_t        exp_q [2][$];
  exp_t        cur [2];
  exp_t        mon_e;
  bit          inflight [2];
  bit          stray_we [2];
  int          gnt_cyc [2];
  logic [15:0] last_rd [2];
  logic [15:0] rd_exp;

  logic [15:0] mem0 [256];
  logic [15:0] q0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .mem_q(mem_q[0]), .mem_addr(mem_addr[0]), .mem_d(mem_d[0]), .mem_we(mem_we[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .rdata(rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut_lat3 (
    .clk(clk), .reset(reset),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .mem_q(mem_q[1]), .mem_addr(mem_addr[1]), .mem_d(mem_d[1]), .mem_we(mem_we[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .rdata(rdata[1]), .busy(busy[1])
  );

  // Synchronous memory with one cycle of read latency for dut_lat1.
  initial begin
    for (int k = 0; k < 256; k++) mem0[k] = 16'h0000;
    mem0[8'h10] = 16'hBEEF;
  end

  always @(posedge clk) begin
    if (mem_we[0]) mem0[mem_addr[0][7:0]] <= mem_d[0];
    q0 <= mem0[mem_addr[0][7:0]];
  end

  assign mem_q[0] = q0;
  // A value that changes every cycle, so a read captured one cycle early or late is visible.
  assign mem_q[1] = 16'hA000 ^ cyc[15:0];

  function automatic int latOf(input int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s (dut%0d): actual 0x%0h, required 0x%0h", name, inst, got, want);
    end
  endtask

  task automatic expectTxn(input int inst, input int port, input bit we,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rd);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = rd;
    exp_q[inst].push_back(e);
  endtask

  // Raise a request and hold it until its grant. With keep set, req stays
  // high so the caller can present the next access straight away.
  task automatic applyStimulus(input int inst, input int port, input bit we,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input bit keep);
    bit seen;
    seen = 1'b0;
    if (port == 0) begin
      we0[inst] = we; addr0[inst] = addr; wdata0[inst] = wdata; req0[inst] = 1'b1;
    end else begin
      we1[inst] = we; addr1[inst] = addr; wdata1[inst] = wdata; req1[inst] = 1'b1;
    end
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk);
      #1;
      if ((port == 0) ? gnt0[inst] : gnt1[inst]) seen = 1'b1;
    end
    checkOutput("gnt_arrives", inst, 64'(seen), 64'd1);
    if (!keep) begin
      if (port == 0) req0[inst] = 1'b0;
      else           req1[inst] = 1'b0;
    end
  endtask

  task automatic waitIdle(input int inst);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 60 && !idle; n++) begin
      @(posedge clk);
      #1;
      if (busy[inst] === 1'b0) idle = 1'b1;
    end
    checkOutput("returns_idle", inst, 64'(idle), 64'd1);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the DUT update.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (inflight[i] && mem_we[i] === 1'b1) stray_we[i] = 1'b1;

      if (gnt0[i] === 1'b1 || gnt1[i] === 1'b1) begin
        checkOutput("gnt_exclusive", i, 64'(gnt0[i] & gnt1[i]), 64'd0);
        checkOutput("gnt_expected", i, 64'(exp_q[i].size() > 0), 64'd1);
        if (exp_q[i].size() > 0) begin
          mon_e = exp_q[i].pop_front();
          checkOutput("gnt_port", i, 64'(gnt1[i]), 64'(mon_e.port));
          checkOutput("access_addr", i, 64'(mem_addr[i]), 64'(mon_e.addr));
          checkOutput("access_we", i, 64'(mem_we[i]), 64'(mon_e.we));
          if (mon_e.we) checkOutput("access_wdata", i, 64'(mem_d[i]), 64'(mon_e.wdata));
          cur[i]      = mon_e;
          inflight[i] = 1'b1;
          stray_we[i] = 1'b0;
          gnt_cyc[i]  = cyc;
        end
      end

      if (done0[i] === 1'b1 || done1[i] === 1'b1) begin
        checkOutput("done_exclusive", i, 64'(done0[i] & done1[i]), 64'd0);
        checkOutput("done_in_flight", i, 64'(inflight[i]), 64'd1);
        if (inflight[i]) begin
          checkOutput("done_port", i, 64'(done1[i]), 64'(cur[i].port));
          checkOutput("done_latency", i, 64'(cyc - gnt_cyc[i]),
                      64'(cur[i].we ? 1 : latOf(i) + 1));
          checkOutput("mem_we_one_cycle", i, 64'(stray_we[i]), 64'd0);
          if (cur[i].we)  rd_exp = last_rd[i];
          else if (i == 1) rd_exp = 16'hA000 ^ 16'(gnt_cyc[i] + latOf(i));
          else            rd_exp = cur[i].rdata;
          checkOutput(cur[i].we ? "rdata_kept_on_write" : "rdata_read", i,
                      64'(rdata[i]), 64'(rd_exp));
          last_rd[i]  = rd_exp;
          inflight[i] = 1'b0;
        end
      end

      if (reset === 1'b0) begin
        inflight[i] = 1'b0;
        last_rd[i]  = 16'h0000;
      end
    end
  end

  // Directed sequence.
  initial begin
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = '0; wdata0[i] = '0;
      req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = '0; wdata1[i] = '0;
      inflight[i] = 1'b0; stray_we[i] = 1'b0; gnt_cyc[i] = 0; last_rd[i] = '0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] reset release");
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_outputs", i,
                  64'({mem_addr[i], mem_d[i], rdata[i], mem_we[i], gnt0[i], gnt1[i],
                       done0[i], done1[i], busy[i]}), 64'd0);
    end

    $display("[TB] single read, READ_LAT=1");
    expectTxn(0, 0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    applyStimulus(0, 0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    waitIdle(0);
    checkOutput("read_result", 0, 64'(rdata[0]), 64'h0000_0000_0000_BEEF);

    $display("[TB] single write from port 1");
    expectTxn(0, 1, 1'b1, 16'h0020, 16'h1234, 16'h0000);
    applyStimulus(0, 1, 1'b1, 16'h0020, 16'h1234, 1'b0);
    waitIdle(0);
    checkOutput("rdata_after_write", 0, 64'(rdata[0]), 64'h0000_0000_0000_BEEF);

    $display("[TB] both ports held, mixed accesses");
    expectTxn(0, 0, 1'b1, 16'h0030, 16'h5555, 16'h0000);
    expectTxn(0, 1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    expectTxn(0, 0, 1'b0, 16'h0030, 16'h0000, 16'h5555);
    expectTxn(0, 1, 1'b1, 16'h0040, 16'hAAAA, 16'h0000);
    expectTxn(0, 0, 1'b0, 16'h0040, 16'h0000, 16'hAAAA);
    expectTxn(0, 1, 1'b0, 16'h0020, 16'h0000, 16'h1234);
    fork
      begin
        applyStimulus(0, 0, 1'b1, 16'h0030, 16'h5555, 1'b1);
        applyStimulus(0, 0, 1'b0, 16'h0030, 16'h0000, 1'b1);
        applyStimulus(0, 0, 1'b0, 16'h0040, 16'h0000, 1'b0);
      end
      begin
        applyStimulus(0, 1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        applyStimulus(0, 1, 1'b1, 16'h0040, 16'hAAAA, 1'b1);
        applyStimulus(0, 1, 1'b0, 16'h0020, 16'h0000, 1'b0);
      end
    join
    waitIdle(0);

    $display("[TB] READ_LAT=3 read and write");
    expectTxn(1, 1, 1'b0, 16'h0050, 16'h0000, 16'h0000);
    applyStimulus(1, 1, 1'b0, 16'h0050, 16'h0000, 1'b0);
    waitIdle(1);
    expectTxn(1, 0, 1'b1, 16'h0060, 16'hCAFE, 16'h0000);
    applyStimulus(1, 0, 1'b1, 16'h0060, 16'hCAFE, 1'b0);
    waitIdle(1);

    $display("[TB] reset during WAIT");
    expectTxn(0, 0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    applyStimulus(0, 0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_outputs", 0,
                64'({mem_addr[0], mem_d[0], rdata[0], mem_we[0], gnt0[0], gnt1[0],
                     done0[0], done1[0], busy[0]}), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("no_done_after_abort", 0, 64'(done0[0]), 64'd0);
    expectTxn(0, 0, 1'b0, 16'h0020, 16'h0000, 16'h1234);
    expectTxn(0, 1, 1'b1, 16'h0030, 16'h7777, 16'h0000);
    fork
      applyStimulus(0, 0, 1'b0, 16'h0020, 16'h0000, 1'b0);
      applyStimulus(0, 1, 1'b1, 16'h0030, 16'h7777, 1'b0);
    join
    waitIdle(0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("scoreboard_drained", i, 64'(exp_q[i].size()), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual time %0t, required finish before 100000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
